// File: rtl/seat_access_arbiter.sv
// Seat-table controller: round-robin arbitration of kiosk check-in/check-out
// requests plus an idle-time sweep that releases seats held past LIMIT ticks.
module seat_access_arbiter #(
    parameter int          NREQ  = 4,
    parameter int          SEATS = 32,
    parameter logic [10:0] LIMIT = 11'd60
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      op_i,
    input  logic [NREQ*25-1:0]   student_no_i,
    input  logic [NREQ*5-1:0]    seat_no_i,
    input  logic [10:0]          time_now_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [1:0]           result_o,
    output logic                 busy_o,
    output logic [SEATS-1:0]     occupied_o,
    output logic                 expire_o,
    output logic [4:0]           expire_seat_o
);

    // state | meaning
    // IDLE  | arbitrate pending requests, otherwise run one sweep step
    // CHECK | validate latched request, write the seat table
    // RESP  | present grant/result, advance round-robin pointer

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = (SEATS > 1) ? $clog2(SEATS) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t             state_q;
    logic [IW-1:0]      rr_q;
    logic [IW-1:0]      win_q;
    logic               op_q;
    logic [24:0]        stu_q;
    logic [4:0]         seat_q;
    logic [SEATS-1:0]   occ_q;
    logic [24:0]        owner_q [SEATS];
    logic [10:0]        stamp_q [SEATS];
    logic [4:0]         sweep_q;
    logic [NREQ-1:0]    grant_q;
    logic [1:0]         result_q;
    logic               expire_q;
    logic [4:0]         expire_seat_q;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [SW-1:0]      seat_idx;
    logic [SW-1:0]      sweep_idx;
    logic               seat_legal;
    logic [1:0]         chk_res;
    logic               chk_set;
    logic               chk_clr;
    logic [10:0]        elapsed;
    logic               sweep_hit;

    // Search begins one past the last winner so every kiosk gets a turn.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_valid && req_i[(int'(rr_q) + k) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    assign seat_idx   = seat_q[SW-1:0];
    assign sweep_idx  = sweep_q[SW-1:0];
    assign seat_legal = ({27'd0, seat_q} < SEATS);

    always_comb begin
        chk_res = 2'b00;
        chk_set = 1'b0;
        chk_clr = 1'b0;
        if (!seat_legal) begin
            chk_res = 2'b11;
        end else if (op_q) begin
            if (occ_q[seat_idx]) chk_res = 2'b01;
            else                 chk_set = 1'b1;
        end else begin
            if (!occ_q[seat_idx] || owner_q[seat_idx] != stu_q) chk_res = 2'b10;
            else                                                 chk_clr = 1'b1;
        end
    end

    // Modulo-2048 difference copes with timer wrap for free.
    assign elapsed   = time_now_i - stamp_q[sweep_idx];
    assign sweep_hit = occ_q[sweep_idx] && (elapsed >= LIMIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            win_q         <= '0;
            op_q          <= 1'b0;
            stu_q         <= '0;
            seat_q        <= '0;
            occ_q         <= '0;
            sweep_q       <= '0;
            grant_q       <= '0;
            result_q      <= 2'b00;
            expire_q      <= 1'b0;
            expire_seat_q <= '0;
            for (int s = 0; s < SEATS; s++) begin
                owner_q[s] <= '0;
                stamp_q[s] <= '0;
            end
        end else begin
            grant_q  <= '0;
            expire_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        win_q   <= pick_idx;
                        op_q    <= op_i[pick_idx];
                        stu_q   <= student_no_i[int'(pick_idx)*25 +: 25];
                        seat_q  <= seat_no_i[int'(pick_idx)*5 +: 5];
                        state_q <= CHECK;
                    end else begin
                        if (sweep_hit) begin
                            occ_q[sweep_idx] <= 1'b0;
                            expire_q         <= 1'b1;
                            expire_seat_q    <= sweep_q;
                        end
                        if (int'(sweep_q) >= SEATS - 1) sweep_q <= '0;
                        else                            sweep_q <= sweep_q + 5'd1;
                    end
                end
                CHECK: begin
                    result_q       <= chk_res;
                    grant_q[win_q] <= 1'b1;
                    if (chk_set) begin
                        occ_q[seat_idx]   <= 1'b1;
                        owner_q[seat_idx] <= stu_q;
                        stamp_q[seat_idx] <= time_now_i;
                    end
                    if (chk_clr) occ_q[seat_idx] <= 1'b0;
                    state_q <= RESP;
                end
                RESP: begin
                    rr_q    <= IW'((int'(win_q) + 1) % NREQ);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign result_o      = result_q;
    assign busy_o        = (state_q != IDLE);
    assign occupied_o    = occ_q;
    assign expire_o      = expire_q;
    assign expire_seat_o = expire_seat_q;

endmodule

// File: tb/tb_seat_access_arbiter.sv
// Directed bench for seat_access_arbiter (SEATS = 16 so illegal seats exist).
module tb_seat_access_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   op;
    logic [99:0]  student;
    logic [19:0]  seat;
    logic [10:0]  tnow;
    logic [3:0]   grant;
    logic [1:0]   result;
    logic         busy;
    logic [15:0]  occupied;
    logic         expire;
    logic [4:0]   expire_seat;

    int pass_cnt  = 0;
    int total_cnt = 0;

    seat_access_arbiter #(.NREQ(4), .SEATS(16), .LIMIT(11'd60)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op),
        .student_no_i(student), .seat_no_i(seat), .time_now_i(tnow),
        .grant_o(grant), .result_o(result), .busy_o(busy),
        .occupied_o(occupied), .expire_o(expire), .expire_seat_o(expire_seat)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; op = '0; student = '0; seat = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives one request and returns what the DUT granted; lat = 99 on timeout.
    task automatic issue(input int idx, input logic o, input logic [24:0] stu,
                         input logic [4:0] s, output logic [3:0] g,
                         output logic [1:0] r, output int lat);
        req[idx] = 1'b1;
        op[idx]  = o;
        student[idx*25 +: 25] = stu;
        seat[idx*5 +: 5]      = s;
        lat = 99;
        g   = '0;
        r   = '0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (grant !== 4'b0000) begin
                lat = c;
                break;
            end
        end
        g = grant;
        r = result;
        req[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; op = '0; student = '0; seat = '0; tnow = 11'd10;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({grant, result, busy, occupied, expire, expire_seat} !== 29'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {grant, result, busy, occupied, expire, expire_seat});
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_checkin_checkout();
        logic [3:0] g; logic [1:0] r; int lat;
        issue(0, 1'b1, 25'h1234, 5'd5, g, r, lat);
        total_cnt++;
        if ({lat, g, r} !== {32'd2, 4'b0001, 2'b00})
            $display("FAIL checkin0: lat %0d grant %b result %b want 2 0001 00", lat, g, r);
        else pass_cnt++;
        total_cnt++;
        if (occupied !== 16'h0020 || busy !== 1'b1)
            $display("FAIL checkin0_occ: occ %h busy %b want 0020 1", occupied, busy);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (grant !== 4'b0000 || result !== 2'b00 || busy !== 1'b0)
            $display("FAIL grant_one_cycle: grant %b result %b busy %b want 0000 00 0", grant, result, busy);
        else pass_cnt++;

        issue(1, 1'b1, 25'h5678, 5'd5, g, r, lat);
        total_cnt++;
        if (g !== 4'b0010 || r !== 2'b01)
            $display("FAIL taken_other: grant %b result %b want 0010 01", g, r);
        else pass_cnt++;

        issue(0, 1'b1, 25'h1234, 5'd5, g, r, lat);
        total_cnt++;
        if (g !== 4'b0001 || r !== 2'b01)
            $display("FAIL taken_same: grant %b result %b want 0001 01", g, r);
        else pass_cnt++;

        issue(1, 1'b0, 25'h5678, 5'd5, g, r, lat);
        total_cnt++;
        if (g !== 4'b0010 || r !== 2'b10 || occupied !== 16'h0020)
            $display("FAIL wrong_owner: grant %b result %b occ %h want 0010 10 0020", g, r, occupied);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (result !== 2'b10)
            $display("FAIL result_hold: got %b want 10", result);
        else pass_cnt++;

        issue(2, 1'b0, 25'h0042, 5'd7, g, r, lat);
        total_cnt++;
        if (g !== 4'b0100 || r !== 2'b10)
            $display("FAIL checkout_empty: grant %b result %b want 0100 10", g, r);
        else pass_cnt++;

        issue(0, 1'b0, 25'h1234, 5'd5, g, r, lat);
        total_cnt++;
        if (g !== 4'b0001 || r !== 2'b00 || occupied !== 16'h0000)
            $display("FAIL checkout_ok: grant %b result %b occ %h want 0001 00 0000", g, r, occupied);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic [3:0] g; logic [1:0] r; int lat;
        issue(3, 1'b1, 25'h0099, 5'd31, g, r, lat);
        total_cnt++;
        if (g !== 4'b1000 || r !== 2'b11 || occupied !== 16'h0000)
            $display("FAIL illegal31: grant %b result %b occ %h want 1000 11 0000", g, r, occupied);
        else pass_cnt++;
        issue(3, 1'b0, 25'h0099, 5'd16, g, r, lat);
        total_cnt++;
        if (r !== 2'b11 || occupied !== 16'h0000)
            $display("FAIL illegal16: result %b occ %h want 11 0000", r, occupied);
        else pass_cnt++;
        issue(3, 1'b1, 25'h0099, 5'd15, g, r, lat);
        total_cnt++;
        if (r !== 2'b00 || occupied !== 16'h8000)
            $display("FAIL legal15: result %b occ %h want 00 8000", r, occupied);
        else pass_cnt++;
        issue(3, 1'b0, 25'h0099, 5'd15, g, r, lat);
        total_cnt++;
        if (r !== 2'b00 || occupied !== 16'h0000)
            $display("FAIL legal15_out: result %b occ %h want 00 0000", r, occupied);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int gap;
        int extra;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op[i] = 1'b1;
            student[i*25 +: 25] = 25'h100 + 25'(i);
            seat[i*5 +: 5]      = 5'(i);
        end
        req = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            gap = 99;
            for (int c = 1; c <= 10; c++) begin
                cyc();
                if (grant !== 4'b0000) begin
                    gap = c;
                    break;
                end
            end
            total_cnt++;
            if (grant !== (4'b0001 << n) || busy !== 1'b1 || gap != ((n == 0) ? 2 : 3))
                $display("FAIL rr_order%0d: grant %b busy %b gap %0d want %b 1 %0d",
                         n, grant, busy, gap, 4'b0001 << n, (n == 0) ? 2 : 3);
            else pass_cnt++;
            req = req & ~grant;
        end
        extra = 0;
        repeat (8) begin
            cyc();
            if (grant !== 4'b0000) extra++;
        end
        total_cnt++;
        if (extra != 0 || occupied !== 16'h000F)
            $display("FAIL rr_once: extra grants %0d occ %h want 0 000f", extra, occupied);
        else pass_cnt++;
    endtask

    task automatic test_expire();
        logic [3:0] g; logic [1:0] r; int lat;
        int pulses;
        int found;
        logic [10:0] tvals [3];
        tvals[0] = 11'd2046;
        tvals[1] = 11'd36;
        tvals[2] = 11'd51;
        do_reset();
        tnow = 11'd2040;
        issue(0, 1'b1, 25'h0ABC, 5'd2, g, r, lat);
        total_cnt++;
        if (r !== 2'b00 || occupied !== 16'h0004)
            $display("FAIL exp_checkin: result %b occ %h want 00 0004", r, occupied);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tnow = tvals[k];
            pulses = 0;
            repeat (40) begin
                cyc();
                if (expire === 1'b1) pulses++;
            end
            total_cnt++;
            if (pulses != 0 || occupied !== 16'h0004)
                $display("FAIL early_expire t=%0d: pulses %0d occ %h want 0 0004", tvals[k], pulses, occupied);
            else pass_cnt++;
        end
        tnow = 11'd52;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (expire === 1'b1) begin
                found = 1;
                break;
            end
        end
        total_cnt++;
        if (found != 1 || expire_seat !== 5'd2 || occupied !== 16'h0000)
            $display("FAIL expire_pulse: found %0d seat %0d occ %h want 1 2 0000", found, expire_seat, occupied);
        else pass_cnt++;
        pulses = 0;
        repeat (20) begin
            cyc();
            if (expire === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses != 0)
            $display("FAIL expire_single: extra pulses %0d want 0", pulses);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] g; logic [1:0] r; int lat;
        int stray;
        tnow = 11'd100;
        req[2] = 1'b1;
        op[2]  = 1'b1;
        student[50 +: 25] = 25'h0777;
        seat[10 +: 5]     = 5'd9;
        cyc();
        total_cnt++;
        if (busy !== 1'b1 || grant !== 4'b0000)
            $display("FAIL mid_in_check: busy %b grant %b want 1 0000", busy, grant);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || grant !== 4'b0000 || occupied !== 16'h0000)
            $display("FAIL mid_abort: busy %b grant %b occ %h want 0 0000 0000", busy, grant, occupied);
        else pass_cnt++;
        req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        stray = 0;
        repeat (4) begin
            cyc();
            if (grant !== 4'b0000) stray++;
        end
        total_cnt++;
        if (stray != 0 || occupied !== 16'h0000)
            $display("FAIL mid_no_grant: stray %0d occ %h want 0 0000", stray, occupied);
        else pass_cnt++;
        issue(0, 1'b1, 25'h1234, 5'd9, g, r, lat);
        total_cnt++;
        if ({lat, g, r} !== {32'd2, 4'b0001, 2'b00} || occupied !== 16'h0200)
            $display("FAIL mid_recover: lat %0d grant %b result %b occ %h want 2 0001 00 0200",
                     lat, g, r, occupied);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_checkin_checkout();
        test_illegal();
        test_round_robin();
        test_expire();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
